// File: rtl/clk_div_monitor.sv
// Divided-clock self-check: measures period/high/low time of div_in in clk cycles,
// declares lock after LOCK_CNT matching periods, and flags ratio and stuck-clock errors.
module clk_div_monitor #(
    parameter int EXP_DIV  = 3,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err_ratio,
    output logic             err_stuck
);

    localparam int MC_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_DIV);
    localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(1);
    localparam logic [MC_W-1:0]  LOCK_VAL = MC_W'(LOCK_CNT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic [2:0]       sync_reg;
    logic             level;
    logic             rise;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] hcnt_reg;
    logic             cnt_sat;
    logic             hcnt_sat;
    logic             ratio_hit;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [MC_W-1:0]  match_cnt_reg;
    logic [MC_W-1:0]  match_cnt_next;
    logic [MC_W-1:0]  match_inc;
    logic             locked_reg;
    logic             locked_next;
    logic             capture;
    logic             ratio_set;
    logic             stuck_set;

    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_time_reg;
    logic [CNT_W-1:0] low_time_reg;
    logic             period_valid_reg;
    logic             err_ratio_reg;
    logic             err_ratio_next;
    logic             err_stuck_reg;
    logic             err_stuck_next;

    // Three-flop chain: two stages for metastability, the third for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], div_in};
        end
    end

    assign level     = sync_reg[1];
    assign rise      = sync_reg[1] & ~sync_reg[2];
    assign cnt_sat   = (cnt_reg == CNT_MAX);
    assign hcnt_sat  = (hcnt_reg == CNT_MAX);
    assign ratio_hit = (cnt_reg == EXP_VAL);
    assign match_inc = match_cnt_reg + MC_ONE;

    // Both counters restart at 1 on the edge itself so the captured value is the full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            hcnt_reg <= '0;
        end else if (rise) begin
            cnt_reg  <= CNT_ONE;
            hcnt_reg <= CNT_ONE;
        end else begin
            if (!cnt_sat) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
            if (level && !hcnt_sat) begin
                hcnt_reg <= hcnt_reg + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        locked_next    = locked_reg;
        capture        = 1'b0;
        ratio_set      = 1'b0;
        stuck_set      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // First edge only arms the counters; there is no complete period yet.
                if (rise) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                    if (ratio_hit) begin
                        match_cnt_next = match_inc;
                        if (match_inc == LOCK_VAL) begin
                            state_next  = ST_LOCKED;
                            locked_next = 1'b1;
                        end
                    end else begin
                        match_cnt_next = '0;
                    end
                end else if (cnt_sat) begin
                    stuck_set      = 1'b1;
                    locked_next    = 1'b0;
                    match_cnt_next = '0;
                    state_next     = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    capture = 1'b1;
                    if (!ratio_hit) begin
                        ratio_set      = 1'b1;
                        locked_next    = 1'b0;
                        match_cnt_next = '0;
                        state_next     = ST_MEASURE;
                    end
                end else if (cnt_sat) begin
                    stuck_set      = 1'b1;
                    locked_next    = 1'b0;
                    match_cnt_next = '0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                match_cnt_next = '0;
                locked_next    = 1'b0;
            end
        endcase
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    assign err_ratio_next = ratio_set | (err_ratio_reg & ~clr_err);
    assign err_stuck_next = stuck_set | (err_stuck_reg & ~clr_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            match_cnt_reg <= '0;
            locked_reg    <= 1'b0;
            err_ratio_reg <= 1'b0;
            err_stuck_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            locked_reg    <= locked_next;
            err_ratio_reg <= err_ratio_next;
            err_stuck_reg <= err_stuck_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_reg       <= '0;
            high_time_reg    <= '0;
            low_time_reg     <= '0;
            period_valid_reg <= 1'b0;
        end else begin
            period_valid_reg <= capture;
            if (capture) begin
                period_reg    <= cnt_reg;
                high_time_reg <= hcnt_reg;
                low_time_reg  <= cnt_reg - hcnt_reg;
            end
        end
    end

    assign period       = period_reg;
    assign high_time    = high_time_reg;
    assign low_time     = low_time_reg;
    assign period_valid = period_valid_reg;
    assign locked       = locked_reg;
    assign err_ratio    = err_ratio_reg;
    assign err_stuck    = err_stuck_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomised and directed bench for clk_div_monitor; an edge-timestamp reference model
// predicts every output on every cycle.
module tb_clk_div_monitor;

    localparam int EXP_DIV  = 3;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int MAXV     = (1 << CNT_W) - 1;
    localparam int SYNC_LAT = 3;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             div_in  = 1'b0;
    logic             clr_err = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic             period_valid;
    logic             locked;
    logic             err_ratio;
    logic             err_stuck;

    clk_div_monitor #(
        .EXP_DIV  (EXP_DIV),
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .div_in       (div_in),
        .clr_err      (clr_err),
        .period       (period),
        .high_time    (high_time),
        .low_time     (low_time),
        .period_valid (period_valid),
        .locked       (locked),
        .err_ratio    (err_ratio),
        .err_stuck    (err_stuck)
    );

    always #5 clk = ~clk;

    int   cyc      = 0;
    logic clr_seen = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) clr_seen <= clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, want);
        end
    endtask

    // Reference model works on edge timestamps as seen after the synchroniser delay.
    int rise_q[$];
    int fall_q[$];
    int m_armed, m_prev_rise, m_prev_fall, m_mc, m_locked, m_err_r, m_err_s;
    int mon_pv, mon_per, mon_hi, mon_set_r, mon_set_s;

    task automatic model_clear();
        rise_q.delete();
        fall_q.delete();
        m_armed     = 0;
        m_prev_rise = 0;
        m_prev_fall = 0;
        m_mc        = 0;
        m_locked    = 0;
        m_err_r     = 0;
        m_err_s     = 0;
    endtask

    always @(negedge clk) begin
        if (rst == 1'b0) begin
            mon_pv    = 0;
            mon_per   = 0;
            mon_hi    = 0;
            mon_set_r = 0;
            mon_set_s = 0;
            if (fall_q.size() > 0 && fall_q[0] == cyc) begin
                void'(fall_q.pop_front());
                m_prev_fall = cyc;
            end
            if (rise_q.size() > 0 && rise_q[0] == cyc) begin
                void'(rise_q.pop_front());
                if (m_armed != 0) begin
                    mon_pv  = 1;
                    mon_per = cyc - m_prev_rise;
                    mon_hi  = m_prev_fall - m_prev_rise;
                    if (m_locked != 0) begin
                        if (mon_per != EXP_DIV) begin
                            m_locked  = 0;
                            m_mc      = 0;
                            mon_set_r = 1;
                        end
                    end else if (mon_per == EXP_DIV) begin
                        m_mc++;
                        if (m_mc == LOCK_CNT) m_locked = 1;
                    end else begin
                        m_mc = 0;
                    end
                end
                m_armed     = 1;
                m_prev_rise = cyc;
            end else if (m_armed != 0 && (cyc - m_prev_rise) == MAXV) begin
                mon_set_s = 1;
                m_locked  = 0;
                m_mc      = 0;
                m_armed   = 0;
            end
            if (clr_seen) begin
                m_err_r = 0;
                m_err_s = 0;
            end
            if (mon_set_r != 0) m_err_r = 1;
            if (mon_set_s != 0) m_err_s = 1;

            check_val("period_valid", int'(period_valid), mon_pv);
            if (mon_pv != 0) begin
                check_val("period", int'(period), mon_per);
                check_val("high_time", int'(high_time), mon_hi);
                check_val("low_time", int'(low_time), mon_per - mon_hi);
            end
            check_val("locked", int'(locked), m_locked);
            check_val("err_ratio", int'(err_ratio), m_err_r);
            check_val("err_stuck", int'(err_stuck), m_err_s);
        end
    end

    // Called at a negedge; one full div_in period of h high and l low clk cycles.
    task automatic drive_period(input int h, input int l);
        div_in = 1'b1;
        rise_q.push_back(cyc + SYNC_LAT);
        repeat (h) @(negedge clk);
        div_in = 1'b0;
        fall_q.push_back(cyc + SYNC_LAT);
        repeat (l) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst     = 1'b1;
        div_in  = 1'b0;
        clr_err = 1'b0;
        model_clear();
        #1;
        check_val("rst_period", int'(period), 0);
        check_val("rst_high_time", int'(high_time), 0);
        check_val("rst_low_time", int'(low_time), 0);
        check_val("rst_period_valid", int'(period_valid), 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_err_ratio", int'(err_ratio), 0);
        check_val("rst_err_stuck", int'(err_stuck), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, h, do_clr;
        model_clear();
        do_reset();

        // Ideal divide-by-3
        repeat (6) drive_period(2, 1);
        check_val("lock_div3", int'(locked), 1);
        check_val("no_err_div3", int'(err_ratio), 0);

        // Switch to divide-by-4 while locked
        repeat (5) drive_period(2, 2);
        check_val("div4_period", int'(period), 4);
        check_val("div4_unlocked", int'(locked), 0);
        check_val("div4_err_ratio", int'(err_ratio), 1);

        // Back to divide-by-3: relock, error stays sticky until cleared
        repeat (6) drive_period(2, 1);
        check_val("relock_div3", int'(locked), 1);
        check_val("err_sticky", int'(err_ratio), 1);
        fork
            repeat (4) drive_period(2, 1);
            begin
                repeat (2) @(negedge clk);
                pulse_clr();
            end
        join
        check_val("err_cleared", int'(err_ratio), 0);
        check_val("clr_keeps_lock", int'(locked), 1);

        // clr_err coincides with a ratio mismatch: set wins
        fork
            begin
                drive_period(2, 2);
                repeat (2) drive_period(2, 1);
            end
            begin
                repeat (6) @(negedge clk);
                pulse_clr();
            end
        join
        check_val("set_beats_clr", int'(err_ratio), 1);
        pulse_clr();
        check_val("clr_alone", int'(err_ratio), 0);

        // Stuck low after lock
        repeat (6) drive_period(2, 1);
        check_val("lock_before_stuck_low", int'(locked), 1);
        repeat (300) @(negedge clk);
        check_val("stuck_low_flag", int'(err_stuck), 1);
        check_val("stuck_low_unlock", int'(locked), 0);
        pulse_clr();
        check_val("stuck_cleared", int'(err_stuck), 0);

        // Stuck high after lock
        repeat (6) drive_period(2, 1);
        check_val("lock_before_stuck_high", int'(locked), 1);
        div_in = 1'b1;
        rise_q.push_back(cyc + SYNC_LAT);
        repeat (300) @(negedge clk);
        check_val("stuck_high_flag", int'(err_stuck), 1);
        check_val("stuck_high_unlock", int'(locked), 0);
        div_in = 1'b0;
        fall_q.push_back(cyc + SYNC_LAT);
        pulse_clr();
        repeat (4) @(negedge clk);

        // Reset while locked, mid-period
        repeat (6) drive_period(2, 1);
        check_val("lock_before_rst", int'(locked), 1);
        div_in = 1'b1;
        rise_q.push_back(cyc + SYNC_LAT);
        @(negedge clk);
        do_reset();
        repeat (4) drive_period(2, 1);
        check_val("no_lock_after_4_edges", int'(locked), 0);
        drive_period(2, 1);
        check_val("lock_after_5_edges", int'(locked), 1);

        // Randomised periods, occasional long gaps and clear pulses
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                p = 250 + $urandom_range(0, 10);
            end else if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(2, 7);
            end else begin
                p = EXP_DIV;
            end
            h      = $urandom_range(1, p - 1);
            do_clr = ($urandom_range(0, 9) == 0) ? 1 : 0;
            fork
                drive_period(h, p - h);
                begin
                    if (do_clr != 0) begin
                        @(negedge clk);
                        pulse_clr();
                    end
                end
            join
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Checks a divided clock inside the core clock domain and reports its ratio. It samples a divided-clock signal (for example, the output of a divide-by-3 stage) on clk. For every period of that signal it measures the period, high time and low time in clk cycles. It declares lock after a run of periods that match the expected ratio, and flags ratio violations and stuck clocks. It sits next to the clock dividers as their self-check and status source.

Parameters:
EXP_DIV, 3, expected divide ratio (clk cycles per div_in period); range 2..2^CNT_W-2
CNT_W, 8, width of the period, high-time and low-time counters
LOCK_CNT, 4, consecutive matching periods required to assert locked; minimum 1

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
div_in  in  1  divided clock under test; may be asynchronous to clk
clr_err  in  1  clears the sticky error flags; single-cycle pulse
period  out  CNT_W  last measured period in clk cycles
high_time  out  CNT_W  clk cycles div_in was high in the last period
low_time  out  CNT_W  clk cycles div_in was low in the last period (period - high_time)
period_valid  out  1  one-cycle pulse when period, high_time and low_time update
locked  out  1  ratio locked to EXP_DIV
err_ratio  out  1  sticky; a period mismatch occurred while locked
err_stuck  out  1  sticky; no rising edge seen within 2^CNT_W-1 cycles

Behaviour:
- Reset: every output is 0; all sync flops, counters and match_cnt are 0; state is IDLE.
- Synchroniser: s1<=div_in, s2<=s1, s3<=s2.
  - rise = s2 & ~s3.
  - Sampled level = s2.
- Cycle counter cnt (CNT_W bits):
  - Loads 1 on rise.
  - Otherwise increments, saturating at MAX = 2^CNT_W-1.
- High counter hcnt:
  - Loads 1 on rise.
  - Otherwise increments while s2=1 (saturating); holds while s2=0.
- States:
  - IDLE:
    - On rise: go to MEASURE and start the counters.
    - No capture and no period_valid on this first edge.
  - MEASURE:
    - On rise: capture period<=cnt, high_time<=hcnt, low_time<=cnt-hcnt, and pulse period_valid for 1 cycle.
    - If cnt==EXP_DIV: match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED and set locked=1 in the same cycle as that period_valid.
    - If cnt!=EXP_DIV: match_cnt<=0. No error is raised in this state.
  - LOCKED:
    - On rise: capture and pulse as in MEASURE.
    - If cnt!=EXP_DIV: locked<=0, err_ratio<=1, match_cnt<=0, go to MEASURE. All of these take effect in the same cycle as that period_valid.
- Stuck detection (MEASURE or LOCKED):
  - When cnt==MAX and there is no rise: err_stuck<=1, locked<=0, match_cnt<=0, go to IDLE.
  - Applies to div_in held at either level.
  - In IDLE, stuck detection is inactive.
- Latency:
  - div_in rises → s2 high 2 cycles later → period_valid and outputs are registered on the following edge, i.e. the 3rd clk edge after div_in is first sampled high.
  - Constant, with no jitter for synchronous stimulus.
- clr_err:
  - Clears err_ratio and err_stuck on the next edge.
  - If a new error event occurs in the same cycle, set wins and the flag stays 1.
  - clr_err does not affect locked or state.
- Outputs hold their last captured values between period_valid pulses.
- Rising edges closer than 2 cycles apart after synchronisation cannot occur: minimum period 2.
- rst asserted mid-operation returns everything to reset values immediately. After release, the first rise is treated as in IDLE.

Test Plan:
- Ideal divide-by-3 (high 2, low 1): first edge gives no pulse; each later edge gives period_valid with period=3, high_time=2, low_time=1; locked=1 with the 4th valid pulse; no errors.
- Once locked, switch div_in to divide-by-4 (high 2, low 2): at the first 4-cycle period, period=4, locked→0, err_ratio→1; after 4 further div-by-4 periods locked stays 0.
- Return to divide-by-3 after the mismatch: locked re-asserts after 4 matching periods; err_ratio stays 1 until clr_err, then reads 0.
- Hold div_in low after lock: exactly 255 cycles after the last captured rise, err_stuck=1, locked=0, state IDLE; repeat with div_in held high and get the same result.
- Pulse clr_err in the same cycle that a ratio mismatch is detected: err_ratio remains 1; a later clr_err alone clears it.
- Assert rst while locked, mid-period: all outputs are 0 immediately; after release a div-by-3 stream needs 1 discard edge plus 4 matches before locked=1.
